// File: rtl/async_fifo_wr_ctrl.sv
// ============================================================================
// async_fifo_wr_ctrl : write-domain controller of the dual-clock FIFO.
// Optional macro ASYNC_FIFO_WR_OVF_EN adds sticky ovf and ovf_cnt.
// Rev 1.0
// ============================================================================
`default_nettype none

module async_fifo_wr_ctrl #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  wclk,
  input  logic                  wrstn,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  wfull,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel
`ifdef ASYNC_FIFO_WR_OVF_EN
  ,
  output logic                  ovf,
  output logic [15:0]           ovf_cnt
`endif
);

  localparam int              PW     = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   AF_LVL = PW'(AF_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rq1_q, rq2_q;
  logic [PW-1:0] rbin_s;
  logic          wfull_q, wfull_d;
  logic          acc;

  assign acc     = in_valid & ~wfull_q;
  assign wbin_d  = wbin_q + PW'(acc);
  assign wgray_d = wbin_d ^ (wbin_d >> 1);

  // Full when the next write pointer sits exactly one lap ahead of the synced read pointer.
  assign wfull_d = (wgray_d == {~rq2_q[PW-1:PW-2], rq2_q[PW-3:0]});

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_s[i] = ^(rq2_q >> i);
    end
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rptr_gray;
      rq2_q   <= rq1_q;
      wfull_q <= wfull_d;
    end
  end

  assign in_ready    = ~wfull_q;
  assign wptr_gray   = wgray_q;
  assign mem_wen     = acc;
  assign mem_waddr   = wbin_q[ADDR_WIDTH-1:0];
  assign mem_wdata   = in_data;
  assign wfull       = wfull_q;
  assign wlevel      = wbin_q - rbin_s;
  assign almost_full = (wlevel >= AF_LVL);

`ifdef ASYNC_FIFO_WR_OVF_EN
  logic        ovf_q, ovf_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic        ovf_hit;

  assign ovf_hit   = in_valid & wfull_q;
  assign ovf_d     = ovf_q | ovf_hit;
  assign ovf_cnt_d = (ovf_hit && (ovf_cnt_q != 16'hFFFF)) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf     = ovf_q;
  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
// ============================================================================
// tb_async_fifo_wr_ctrl : randomized bench for async_fifo_wr_ctrl (DEPTH=16).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_async_fifo_wr_ctrl;

  logic       wclk = 1'b0;
  logic       wrstn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [4:0] rptr_gray;
  logic [4:0] wptr_gray;
  logic       mem_wen;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       wfull;
  logic       almost_full;
  logic [4:0] wlevel;
`ifdef ASYNC_FIFO_WR_OVF_EN
  logic        ovf;
  logic [15:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: plain occupancy arithmetic on unbounded counters.
  int  m_wcnt;   // words accepted since reset
  int  m_rd;     // words the read side has consumed (driven pointer)
  int  m_r1, m_r2;
  bit  m_full;
  int  n_wen;
  int  max_level;
  bit  saw_full;

  async_fifo_wr_ctrl #(.DEPTH(16), .WIDTH(8), .AF_THRESH(14)) dut (
    .wclk        (wclk),
    .wrstn       (wrstn),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .rptr_gray   (rptr_gray),
    .wptr_gray   (wptr_gray),
    .mem_wen     (mem_wen),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .wfull       (wfull),
    .almost_full (almost_full),
    .wlevel      (wlevel)
`ifdef ASYNC_FIFO_WR_OVF_EN
    ,
    .ovf         (ovf),
    .ovf_cnt     (ovf_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    rptr_gray = '0;
    wrstn     = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrstn  = 1'b1;
    m_wcnt = 0; m_rd = 0; m_r1 = 0; m_r2 = 0; m_full = 0;
    n_wen = 0; max_level = 0; saw_full = 0;
  endtask

  // One wclk cycle of stimulus with full model comparison before and after the edge.
  task automatic step(input logic v);
    logic acc;
    int   lvl;
    in_valid  = v;
    in_data   = 8'($urandom);
    rptr_gray = gray(m_rd);
    #1;
    acc = v & ~m_full;
    checks++;
    if (mem_wen !== acc) begin
      errors++; $display("FAIL mem_wen: got %b want %b (wcnt=%0d)", mem_wen, acc, m_wcnt);
    end
    if (acc) begin
      n_wen++;
      checks++;
      if (mem_waddr !== 4'(m_wcnt % 16)) begin
        errors++; $display("FAIL mem_waddr: got %0d want %0d", mem_waddr, m_wcnt % 16);
      end
      checks++;
      if (mem_wdata !== in_data) begin
        errors++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, in_data);
      end
    end
    @(posedge wclk);
    m_wcnt = m_wcnt + int'(acc);
    m_full = ((m_wcnt - m_r2) == 16);
    m_r2   = m_r1;
    m_r1   = m_rd;
    lvl    = m_wcnt - m_r2;
    if (lvl > max_level) max_level = lvl;
    #1;
    if (wfull === 1'b1) saw_full = 1;
    checks++;
    if (wptr_gray !== gray(m_wcnt)) begin
      errors++; $display("FAIL wptr_gray: got %b want %b", wptr_gray, gray(m_wcnt));
    end
    checks++;
    if (wfull !== m_full || in_ready !== !m_full) begin
      errors++; $display("FAIL full/ready: got %b/%b want %b/%b", wfull, in_ready, m_full, !m_full);
    end
    checks++;
    if (wlevel !== 5'(lvl)) begin
      errors++; $display("FAIL wlevel: got %0d want %0d", wlevel, lvl);
    end
    checks++;
    if (almost_full !== (lvl >= 14)) begin
      errors++; $display("FAIL almost_full: got %b want %b (lvl=%0d)", almost_full, lvl >= 14, lvl);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (wptr_gray !== 5'd0 || wfull !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ptr_full: got gray=%b full=%b ready=%b want 0/0/1", wptr_gray, wfull, in_ready);
    end
    checks++;
    if (wlevel !== 5'd0 || almost_full !== 1'b0 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL reset_level: got lvl=%0d af=%b wen=%b want 0/0/0", wlevel, almost_full, mem_wen);
    end
  endtask

  task automatic test_fill_and_release();
    int edges;
    do_reset();
    repeat (20) step(1'b1);
    checks++;
    if (n_wen !== 16) begin
      errors++; $display("FAIL fill_wen_count: got %0d want 16", n_wen);
    end
    checks++;
    if (wptr_gray !== 5'b11000 || wlevel !== 5'd16 || wfull !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_state: got gray=%b lvl=%0d full=%b ready=%b want 11000/16/1/0",
                         wptr_gray, wlevel, wfull, in_ready);
    end
    m_rd  = 1;
    edges = 0;
    while (wfull === 1'b1 && edges < 3) begin
      step(1'b0);
      edges++;
    end
    checks++;
    if (wfull !== 1'b0 || wlevel !== 5'd15) begin
      errors++; $display("FAIL release: got full=%b lvl=%0d after %0d edges want 0/15", wfull, wlevel, edges);
    end
    n_wen = 0;
    step(1'b1);
    checks++;
    if (n_wen !== 1 || wfull !== 1'b1) begin
      errors++; $display("FAIL refill: got wen=%0d full=%b want 1/1", n_wen, wfull);
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    repeat (13) step(1'b1);
    checks++;
    if (almost_full !== 1'b0) begin
      errors++; $display("FAIL af_13: got %b want 0", almost_full);
    end
    step(1'b1);
    checks++;
    if (almost_full !== 1'b1) begin
      errors++; $display("FAIL af_14: got %b want 1", almost_full);
    end
  endtask

  task automatic test_wrap();
    int guard;
    do_reset();
    guard = 0;
    while (m_wcnt < 40 && guard < 400) begin
      m_rd = (m_wcnt >= 4) ? m_wcnt - 4 : 0;
      step(($urandom % 4) != 0);
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (saw_full || n_wen !== 40) begin
      errors++; $display("FAIL wrap_nofull: got saw_full=%0d wen=%0d want 0/40", saw_full, n_wen);
    end
    checks++;
    if (wptr_gray !== 5'b01100) begin
      errors++; $display("FAIL wrap_ptr: got %b want 01100", wptr_gray);
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (300) begin
      if (m_rd < m_wcnt && ($urandom % 3) == 0) m_rd = m_rd + 1;
      step(($urandom % 4) != 0);
    end
    checks++;
    if (max_level > 16) begin
      errors++; $display("FAIL random_level_bound: got %0d want <=16", max_level);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (7) step(1'b1);
    in_valid = 1'b0;
    #3;
    wrstn = 1'b0;
    #1;
    checks++;
    if (wptr_gray !== 5'd0 || wfull !== 1'b0 || wlevel !== 5'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset: got gray=%b full=%b lvl=%0d ready=%b want 0/0/0/1",
                         wptr_gray, wfull, wlevel, in_ready);
    end
    @(negedge wclk);
    wrstn  = 1'b1;
    m_wcnt = 0; m_rd = 0; m_r1 = 0; m_r2 = 0; m_full = 0; n_wen = 0;
    step(1'b1);
    checks++;
    if (n_wen !== 1 || wptr_gray !== 5'b00001) begin
      errors++; $display("FAIL midreset_first_write: got wen=%0d gray=%b want 1/00001", n_wen, wptr_gray);
    end
  endtask

`ifdef ASYNC_FIFO_WR_OVF_EN
  task automatic test_overflow();
    do_reset();
    repeat (16) step(1'b1);
    repeat (5) step(1'b1);
    checks++;
    if (ovf_cnt !== 16'd5 || ovf !== 1'b1 || n_wen !== 16) begin
      errors++; $display("FAIL ovf: got cnt=%0d ovf=%b wen=%0d want 5/1/16", ovf_cnt, ovf, n_wen);
    end
    do_reset();
    #1;
    checks++;
    if (ovf_cnt !== 16'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_reset: got cnt=%0d ovf=%b want 0/0", ovf_cnt, ovf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_and_release();
    test_almost_full();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef ASYNC_FIFO_WR_OVF_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
